// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring integer divider.
// Responder side of the divide handshake. The initiator holds div_start high
// until it samples div_end. A new quotient bit is resolved on every clock edge.
// Signed operands are divided as magnitudes, and the signs are applied when
// the result is registered. quotient/remainder/div_0 hold their values between
// completions so the ALU can keep forwarding them.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_cancel,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] dividsor_i,
  output logic             div_0,
  output logic             div_end,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;     // iterations completed in BUSY
  logic [WIDTH-1:0] rem_q;     // partial remainder (magnitude)
  logic [WIDTH-1:0] shreg_q;   // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvsr_q;    // divisor magnitude
  logic             neg_quo_q; // operand signs differ: negate quotient
  logic             neg_rem_q; // dividend negative: negate remainder

  // Launch-time operand conditioning
  logic             launch;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic             divisor_zero;

  // One restoring step
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             last_iter;

  // Sign-corrected results, used on the final iteration
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  assign launch       = (state_q == IDLE) && div_start && !div_cancel;
  assign dividend_neg = is_signed && dividend_i[WIDTH-1];
  assign divisor_neg  = is_signed && dividsor_i[WIDTH-1];
  // Negating the most negative value gives the same bits. Read as unsigned,
  // those bits are the correct magnitude.
  assign dividend_mag = dividend_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign divisor_mag  = divisor_neg  ? (~dividsor_i + 1'b1) : dividsor_i;
  assign divisor_zero = (dividsor_i == '0);

  // The partial remainder keeps its top bit in the shift. A remainder with
  // bit WIDTH-1 set can occur for unsigned divisors above 2^(WIDTH-1). Once
  // shifted, that value always exceeds the divisor, so the subtraction succeeds
  // and the difference fits back into WIDTH bits.
  assign shifted   = {rem_q, shreg_q[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvsr_q};
  assign trial_ok  = !trial[WIDTH];
  assign rem_next  = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next  = {shreg_q[WIDTH-2:0], trial_ok};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  assign quo_final = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
  assign rem_final = neg_rem_q ? (~rem_next + 1'b1) : rem_next;

  // The completion pulse is decoded from the state register, so it is glitch-free and one cycle wide.
  assign div_end = (state_q == DONE);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // flop samples values from before the edge, whatever the block order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    // NOTE: a default is assigned first, so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = divisor_zero ? DONE : BUSY;
      end
      BUSY: begin
        if (div_cancel)     state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture at launch, one step per BUSY edge, result registration
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      shreg_q   <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_0     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            shreg_q   <= dividend_mag;
            dvsr_q    <= divisor_mag;
            neg_quo_q <= dividend_neg ^ divisor_neg;
            neg_rem_q <= dividend_neg;
            if (divisor_zero) begin
              // Divide by zero completes immediately with fixed results
              quotient  <= '1;
              remainder <= dividend_i;
              div_0     <= 1'b1;
            end
          end
        end
        BUSY: begin
          // A cancel freezes everything. The outputs keep the previous result.
          if (!div_cancel) begin
            rem_q   <= rem_next;
            shreg_q <= quo_next;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_iter) begin
              quotient  <= quo_final;
              remainder <= rem_final;
              div_0     <= 1'b0;
            end
          end
        end
        default: ;  // DONE: results already registered, nothing to update
      endcase
    end
  end

endmodule
